// File: rtl/cpu_pkg.sv
// Shared opcode/funct encodings, FSM state and ALU control types for mc_cpu_core.
// Latency: n/a (types, constants and pure decode helpers only).
// Backpressure: n/a. CPU_MUL_EN adds the R-type mul funct to the legal set.
package cpu_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_MUL = 6'h18;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_MEM,
        ST_WB,
        ST_HALT
    } state_t;

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_MUL
    } alu_ctrl_t;

    // True when an R-type funct field names an implemented operation.
    function automatic logic funct_legal(input logic [5:0] f);
        logic ok;
        ok = 1'b0;
        case (f)
            FN_ADD, FN_SUB, FN_AND, FN_OR: ok = 1'b1;
`ifdef CPU_MUL_EN
            FN_MUL: ok = 1'b1;
`endif
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Map an R-type funct field to the ALU operation; illegal functs never reach EXEC.
    function automatic alu_ctrl_t funct_alu(input logic [5:0] f);
        alu_ctrl_t c;
        c = ALU_ADD;
        case (f)
            FN_SUB: c = ALU_SUB;
            FN_AND: c = ALU_AND;
            FN_OR:  c = ALU_OR;
`ifdef CPU_MUL_EN
            FN_MUL: c = ALU_MUL;
`endif
            default: c = ALU_ADD;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/mc_alu.sv
// Combinational integer ALU: add/sub/and/or, plus mul when CPU_MUL_EN is defined.
// Latency: 0 cycles (purely combinational), results wrap modulo 2^XLEN.
// Backpressure: none.
module mc_alu
    import cpu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  alu_ctrl_t        ctrl,
    input  logic [XLEN-1:0]  a,
    input  logic [XLEN-1:0]  b,
    output logic [XLEN-1:0]  y
);

    // Select the operation; mul keeps only the low XLEN bits of the product.
    always_comb begin
        y = a + b;
        case (ctrl)
            ALU_SUB: y = a - b;
            ALU_AND: y = a & b;
            ALU_OR:  y = a | b;
`ifdef CPU_MUL_EN
            ALU_MUL: y = a * b;
`endif
            default: y = a + b;
        endcase
    end

endmodule

// File: rtl/mc_cpu_core.sv
// Multi-cycle CPU core (FETCH/DECODE/EXEC/MEM/WB); CPU_MUL_EN enables R-type mul.
// Latency with zero-wait acks: R-type/addi 4, beq 3, sw 4, lw 5 cycles.
// Backpressure: FETCH and MEM hold their request stable until the matching ack.
module mc_cpu_core
    import cpu_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter int              NREG     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    output logic             imem_req_o,
    output logic [XLEN-1:0]  imem_addr_o,
    input  logic             imem_ack_i,
    input  logic [31:0]      imem_data_i,
    output logic             dmem_req_o,
    output logic             dmem_we_o,
    output logic [XLEN-1:0]  dmem_addr_o,
    output logic [XLEN-1:0]  dmem_wdata_o,
    input  logic             dmem_ack_i,
    input  logic [XLEN-1:0]  dmem_rdata_i,
    output logic             halt_o,
    output logic [XLEN-1:0]  pc_o
);

    localparam int RW = $clog2(NREG);

    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_q;
    logic [31:0]     ir_q;
    logic [XLEN-1:0] a_q, b_q, imm_q, res_q;
    alu_ctrl_t       ctrl_q;
    logic [RW-1:0]   wb_idx_q;
    logic [XLEN-1:0] regs [NREG];

    // Instruction fields; register indices are truncated to the register-file width.
    logic [5:0]      op, funct;
    logic [RW-1:0]   rs_idx, rt_idx, rd_idx;
    logic [XLEN-1:0] imm_ext, rs_val, rt_val, alu_b, alu_y, pc_plus4, br_target;
    logic            legal;

    assign op        = ir_q[31:26];
    assign funct     = ir_q[5:0];
    assign rs_idx    = ir_q[21 +: RW];
    assign rt_idx    = ir_q[16 +: RW];
    assign rd_idx    = ir_q[11 +: RW];
    assign imm_ext   = {{(XLEN-16){ir_q[15]}}, ir_q[15:0]};
    assign rs_val    = (rs_idx == '0) ? '0 : regs[rs_idx];
    assign rt_val    = (rt_idx == '0) ? '0 : regs[rt_idx];
    assign pc_plus4  = pc_q + XLEN'(4);
    assign br_target = pc_plus4 + (imm_q << 2);
    assign alu_b     = (op == OP_RTYPE) ? b_q : imm_q;

    assign imem_addr_o = pc_q;
    assign pc_o        = pc_q;

    // Instruction legality, evaluated on the latched word during DECODE.
    always_comb begin
        legal = 1'b0;
        case (op)
            OP_RTYPE: legal = funct_legal(funct);
            OP_ADDI, OP_LW, OP_SW, OP_BEQ: legal = 1'b1;
            default: legal = 1'b0;
        endcase
    end

    mc_alu #(.XLEN(XLEN)) u_alu (
        .ctrl (ctrl_q),
        .a    (a_q),
        .b    (alu_b),
        .y    (alu_y)
    );

    // State register; reset returns to IDLE so any in-flight request drops at once.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next state and bus outputs; outputs derive only from registered state.
    always_comb begin
        state_d      = state_q;
        imem_req_o   = 1'b0;
        dmem_req_o   = 1'b0;
        dmem_we_o    = 1'b0;
        dmem_addr_o  = '0;
        dmem_wdata_o = '0;
        halt_o       = 1'b0;
        case (state_q)
            ST_IDLE:   if (start_i) state_d = ST_FETCH;
            ST_FETCH: begin
                imem_req_o = 1'b1;
                if (imem_ack_i) state_d = ST_DECODE;
            end
            ST_DECODE: state_d = legal ? ST_EXEC : ST_HALT;
            ST_EXEC: begin
                case (op)
                    OP_RTYPE, OP_ADDI: state_d = ST_WB;
                    OP_LW, OP_SW:      state_d = ST_MEM;
                    OP_BEQ:            state_d = ST_FETCH;
                    default:           state_d = ST_HALT;
                endcase
            end
            ST_MEM: begin
                dmem_req_o   = 1'b1;
                dmem_addr_o  = res_q;
                dmem_we_o    = (op == OP_SW);
                dmem_wdata_o = (op == OP_SW) ? b_q : '0;
                if (dmem_ack_i) state_d = (op == OP_SW) ? ST_FETCH : ST_WB;
            end
            ST_WB:   state_d = ST_FETCH;
            ST_HALT: halt_o = 1'b1;
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath: latch instruction, operands, ALU/load result and advance the PC.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            pc_q     <= RESET_PC;
            ir_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            imm_q    <= '0;
            res_q    <= '0;
            ctrl_q   <= ALU_ADD;
            wb_idx_q <= '0;
        end else begin
            case (state_q)
                ST_FETCH: if (imem_ack_i) ir_q <= imem_data_i;
                ST_DECODE: begin
                    a_q      <= rs_val;
                    b_q      <= rt_val;
                    imm_q    <= imm_ext;
                    ctrl_q   <= (op == OP_RTYPE) ? funct_alu(funct) : ALU_ADD;
                    wb_idx_q <= (op == OP_RTYPE) ? rd_idx : rt_idx;
                end
                ST_EXEC: begin
                    res_q <= alu_y;
                    if (op == OP_BEQ) pc_q <= (a_q == b_q) ? br_target : pc_plus4;
                end
                ST_MEM: begin
                    if (dmem_ack_i) begin
                        if (op == OP_SW) pc_q  <= pc_plus4;
                        else             res_q <= dmem_rdata_i;
                    end
                end
                ST_WB:   pc_q <= pc_plus4;
                default: ;
            endcase
        end
    end

    // Register file; register 0 is never written so it always reads zero.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else if (state_q == ST_WB && wb_idx_q != '0) begin
            regs[wb_idx_q] <= res_q;
        end
    end

endmodule

// File: tb/tb_mc_cpu_core.sv
// Directed bench for mc_cpu_core with a behavioural instruction/data memory responder.
// Latency: checks per-instruction fetch spacing against hand-computed cycle counts.
// Backpressure: exercises delayed imem acks, delayed dmem acks and reset mid-request.
module tb_mc_cpu_core;

    localparam int XLEN = 32;
    localparam logic [31:0] ILL = 32'hFC00_0000;

    logic            clk = 1'b0;
    logic            rst_i, start_i;
    logic            imem_req_o, imem_ack_i;
    logic [XLEN-1:0] imem_addr_o;
    logic [31:0]     imem_data_i;
    logic            dmem_req_o, dmem_we_o, dmem_ack_i;
    logic [XLEN-1:0] dmem_addr_o, dmem_wdata_o, dmem_rdata_i;
    logic            halt_o;
    logic [XLEN-1:0] pc_o;

    mc_cpu_core #(.XLEN(XLEN), .NREG(32), .RESET_PC('0)) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .start_i      (start_i),
        .imem_req_o   (imem_req_o),
        .imem_addr_o  (imem_addr_o),
        .imem_ack_i   (imem_ack_i),
        .imem_data_i  (imem_data_i),
        .dmem_req_o   (dmem_req_o),
        .dmem_we_o    (dmem_we_o),
        .dmem_addr_o  (dmem_addr_o),
        .dmem_wdata_o (dmem_wdata_o),
        .dmem_ack_i   (dmem_ack_i),
        .dmem_rdata_i (dmem_rdata_i),
        .halt_o       (halt_o),
        .pc_o         (pc_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Memory model state: imem written only by the main sequence, dmem only by the responder.
    logic [31:0] imem [16];
    logic [31:0] dmem [16];
    int          imem_delay = 0;
    int          dmem_delay = 0;
    logic        stray_dack = 1'b0;
    int          cyc = 0;
    int          overlap = 0;
    int          req_in_halt = 0;
    int          unstable = 0;
    logic [31:0] f_addr [$];
    int          f_cyc  [$];
    logic [31:0] w_addr [$];
    logic [31:0] w_data [$];

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] fn);
        return {6'h00, rs, rt, rd, 5'd0, fn};
    endfunction

    // Responder: updates acks on each falling edge and logs fetches and stores.
    initial begin
        int          iwait;
        int          dwait;
        logic [31:0] ihold;
        iwait = 0;
        dwait = 0;
        ihold = '0;
        for (int i = 0; i < 16; i++) dmem[i] = '0;
        imem_ack_i   = 1'b0;
        imem_data_i  = '0;
        dmem_ack_i   = 1'b0;
        dmem_rdata_i = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (imem_req_o && dmem_req_o) overlap++;
            if (halt_o && (imem_req_o || dmem_req_o)) req_in_halt++;
            imem_ack_i = 1'b0;
            if (imem_req_o) begin
                if (iwait > 0 && imem_addr_o != ihold) unstable++;
                ihold = imem_addr_o;
                if (iwait >= imem_delay) begin
                    imem_ack_i  = 1'b1;
                    imem_data_i = imem[imem_addr_o[5:2]];
                    f_addr.push_back(imem_addr_o);
                    f_cyc.push_back(cyc);
                    iwait = 0;
                end else begin
                    iwait++;
                end
            end else begin
                iwait = 0;
            end
            dmem_ack_i = 1'b0;
            if (dmem_req_o) begin
                if (dwait >= dmem_delay) begin
                    dmem_ack_i = 1'b1;
                    if (dmem_we_o) begin
                        dmem[dmem_addr_o[5:2]] = dmem_wdata_o;
                        w_addr.push_back(dmem_addr_o);
                        w_data.push_back(dmem_wdata_o);
                    end else begin
                        dmem_rdata_i = dmem[dmem_addr_o[5:2]];
                    end
                    dwait = 0;
                end else begin
                    dwait++;
                end
            end else begin
                dwait = 0;
                if (stray_dack) begin
                    dmem_ack_i   = 1'b1;
                    dmem_rdata_i = '1;
                end
            end
        end
    end

    task automatic run(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        start_i = 1'b0;
        @(negedge clk);
        rst_i = 1'b0;
        repeat (2) @(negedge clk);
        rst_i = 1'b1;
        @(negedge clk);
        #1;
    endtask

    task automatic do_start();
        start_i = 1'b1;
        @(negedge clk);
        #1;
        start_i = 1'b0;
    endtask

    task automatic clear_prog();
        for (int i = 0; i < 16; i++) imem[i] = ILL;
    endtask

    int fb, wb, hb;
    int exp_gap [7];
    logic [31:0] exp_fa [8];

    initial begin
        rst_i   = 1'b1;
        start_i = 1'b0;
        clear_prog();

        // ---- Reset values, then main program: ALU, sw/lw, r0 write, illegal opcode ----
        @(negedge clk);
        rst_i = 1'b0;
        #1;
        check_eq("rst_pc",     64'(pc_o), 64'h0);
        check_eq("rst_halt",   64'(halt_o), 64'h0);
        check_eq("rst_ireq",   64'(imem_req_o), 64'h0);
        check_eq("rst_dreq",   64'(dmem_req_o), 64'h0);
        check_eq("rst_dwe",    64'(dmem_we_o), 64'h0);
        check_eq("rst_daddr",  64'(dmem_addr_o), 64'h0);
        check_eq("rst_dwdata", 64'(dmem_wdata_o), 64'h0);
        imem[0] = enc_i(6'h08, 5'd0, 5'd1, 16'd5);       // addi r1,r0,5
        imem[1] = enc_r(5'd1, 5'd1, 5'd2, 6'h20);        // add  r2,r1,r1
        imem[2] = enc_i(6'h2B, 5'd0, 5'd2, 16'd4);       // sw   r2,4(r0)
        imem[3] = enc_i(6'h23, 5'd0, 5'd3, 16'd4);       // lw   r3,4(r0)
        imem[4] = enc_i(6'h2B, 5'd0, 5'd3, 16'd8);       // sw   r3,8(r0)
        imem[5] = enc_i(6'h08, 5'd0, 5'd0, 16'd7);       // addi r0,r0,7
        imem[6] = enc_i(6'h2B, 5'd0, 5'd0, 16'd12);      // sw   r0,12(r0)
        imem[7] = ILL;
        repeat (2) @(negedge clk);
        rst_i = 1'b1;
        run(3);
        check_eq("idle_no_req", 64'(imem_req_o), 64'h0);
        fb = f_addr.size();
        wb = w_addr.size();
        hb = req_in_halt;
        do_start();
        run(40);
        exp_fa  = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h10, 32'h14, 32'h18, 32'h1C};
        exp_gap = '{4, 4, 4, 5, 4, 4, 4};
        check_eq("p1_nfetch", 64'(f_addr.size() - fb), 64'd8);
        if (f_addr.size() - fb >= 8) begin
            for (int i = 0; i < 8; i++)
                check_eq($sformatf("p1_faddr%0d", i), 64'(f_addr[fb+i]), 64'(exp_fa[i]));
            for (int i = 0; i < 7; i++)
                check_eq($sformatf("p1_gap%0d", i), 64'(f_cyc[fb+i+1] - f_cyc[fb+i]), 64'(exp_gap[i]));
        end
        check_eq("p1_nwrite", 64'(w_addr.size() - wb), 64'd3);
        if (w_addr.size() - wb >= 3) begin
            check_eq("sw_r2_addr", 64'(w_addr[wb]),   64'd4);
            check_eq("sw_r2_data", 64'(w_data[wb]),   64'd10);
            check_eq("lw_r3_data", 64'(w_data[wb+1]), 64'd10);
            check_eq("r0_stays_0", 64'(w_data[wb+2]), 64'd0);
        end
        check_eq("ill_halt",    64'(halt_o), 64'h1);
        check_eq("ill_pc",      64'(pc_o), 64'h1C);
        check_eq("halt_no_req", 64'(req_in_halt - hb), 64'd0);

        // ---- Delayed instruction ack: request held, one instruction retired ----
        clear_prog();
        imem[0] = enc_i(6'h08, 5'd0, 5'd1, 16'd5);
        imem_delay = 3;
        do_reset();
        check_eq("rst_clears_halt", 64'(halt_o), 64'h0);
        fb = f_addr.size();
        hb = unstable;
        do_start();
        run(30);
        check_eq("dly_nfetch",   64'(f_addr.size() - fb), 64'd2);
        if (f_addr.size() - fb >= 2)
            check_eq("dly_gap", 64'(f_cyc[fb+1] - f_cyc[fb]), 64'd7);
        check_eq("dly_stable",   64'(unstable - hb), 64'd0);
        check_eq("dly_pc",       64'(pc_o), 64'h4);
        check_eq("dly_halt",     64'(halt_o), 64'h1);
        imem_delay = 0;

        // ---- Branches: not-taken, taken forward, self-loop at 0x10 ----
        clear_prog();
        imem[0] = enc_i(6'h08, 5'd0, 5'd1, 16'd1);       // addi r1,r0,1
        imem[1] = enc_i(6'h04, 5'd1, 5'd0, 16'd1);       // beq  r1,r0,+1 (not taken)
        imem[2] = enc_i(6'h04, 5'd0, 5'd0, 16'd1);       // beq  r0,r0,+1 -> 0x10
        imem[4] = enc_i(6'h04, 5'd1, 5'd1, 16'hFFFF);    // beq  r1,r1,-1 -> 0x10
        do_reset();
        fb = f_addr.size();
        do_start();
        run(25);
        check_eq("br_nfetch_ge5", 64'(f_addr.size() - fb >= 5), 64'd1);
        if (f_addr.size() - fb >= 5) begin
            check_eq("br_nt_addr",   64'(f_addr[fb+2]), 64'h08);
            check_eq("br_fwd_addr",  64'(f_addr[fb+3]), 64'h10);
            check_eq("br_loop_addr", 64'(f_addr[fb+4]), 64'h10);
            check_eq("br_gap",       64'(f_cyc[fb+2] - f_cyc[fb+1]), 64'd3);
        end
        check_eq("br_no_halt", 64'(halt_o), 64'h0);

        // ---- sub/and/or with a negative immediate and negative store offset ----
        clear_prog();
        imem[0] = enc_i(6'h08, 5'd0, 5'd1, 16'hFFFD);    // addi r1,r0,-3
        imem[1] = enc_i(6'h08, 5'd0, 5'd2, 16'd12);      // addi r2,r0,12
        imem[2] = enc_r(5'd2, 5'd1, 5'd3, 6'h22);        // sub  r3,r2,r1
        imem[3] = enc_r(5'd1, 5'd2, 5'd4, 6'h24);        // and  r4,r1,r2
        imem[4] = enc_r(5'd1, 5'd2, 5'd5, 6'h25);        // or   r5,r1,r2
        imem[5] = enc_i(6'h2B, 5'd0, 5'd3, 16'd0);       // sw   r3,0(r0)
        imem[6] = enc_i(6'h2B, 5'd0, 5'd4, 16'd4);       // sw   r4,4(r0)
        imem[7] = enc_i(6'h2B, 5'd2, 5'd5, 16'hFFFC);    // sw   r5,-4(r2)
        do_reset();
        wb = w_addr.size();
        do_start();
        run(45);
        check_eq("alu_nwrite", 64'(w_addr.size() - wb), 64'd3);
        if (w_addr.size() - wb >= 3) begin
            check_eq("sub_data",  64'(w_data[wb]),   64'd15);
            check_eq("and_data",  64'(w_data[wb+1]), 64'h0000_000C);
            check_eq("or_data",   64'(w_data[wb+2]), 64'hFFFF_FFFD);
            check_eq("neg_off",   64'(w_addr[wb+2]), 64'h8);
        end

        // ---- mul funct: computes with CPU_MUL_EN, traps without ----
        clear_prog();
        imem[0] = enc_i(6'h08, 5'd0, 5'd1, 16'd6);       // addi r1,r0,6
        imem[1] = enc_i(6'h08, 5'd0, 5'd2, 16'd7);       // addi r2,r0,7
        imem[2] = enc_r(5'd1, 5'd2, 5'd3, 6'h18);        // mul  r3,r1,r2
        imem[3] = enc_i(6'h2B, 5'd0, 5'd3, 16'd0);       // sw   r3,0(r0)
        do_reset();
        fb = f_addr.size();
        wb = w_addr.size();
        do_start();
        run(30);
`ifdef CPU_MUL_EN
        check_eq("mul_nwrite", 64'(w_addr.size() - wb), 64'd1);
        if (w_addr.size() - wb >= 1)
            check_eq("mul_data", 64'(w_data[wb]), 64'd42);
        if (f_addr.size() - fb >= 4)
            check_eq("mul_gap", 64'(f_cyc[fb+3] - f_cyc[fb+2]), 64'd4);
        check_eq("mul_pc", 64'(pc_o), 64'h10);
`else
        check_eq("mul_nwrite", 64'(w_addr.size() - wb), 64'd0);
        check_eq("mul_pc",     64'(pc_o), 64'h8);
`endif
        check_eq("mul_halt", 64'(halt_o), 64'h1);

        // ---- Reset in the middle of a data access, then a stray ack ----
        clear_prog();
        imem[0] = enc_i(6'h08, 5'd0, 5'd1, 16'd9);       // addi r1,r0,9
        imem[1] = enc_i(6'h2B, 5'd0, 5'd1, 16'd0);       // sw   r1,0(r0)
        dmem_delay = 4;
        do_reset();
        do_start();
        for (int i = 0; i < 30 && !dmem_req_o; i++) @(negedge clk);
        check_eq("mem_reached", 64'(dmem_req_o), 64'h1);
        #2;
        rst_i = 1'b0;
        #1;
        check_eq("mrst_dreq",  64'(dmem_req_o), 64'h0);
        check_eq("mrst_dwe",   64'(dmem_we_o), 64'h0);
        check_eq("mrst_daddr", 64'(dmem_addr_o), 64'h0);
        check_eq("mrst_pc",    64'(pc_o), 64'h0);
        wb = w_addr.size();
        dmem_delay = 0;
        @(negedge clk);
        #1;
        rst_i = 1'b1;
        stray_dack = 1'b1;
        @(negedge clk);
        #1;
        stray_dack = 1'b0;
        run(3);
        check_eq("stray_dreq",   64'(dmem_req_o), 64'h0);
        check_eq("stray_ireq",   64'(imem_req_o), 64'h0);
        check_eq("stray_pc",     64'(pc_o), 64'h0);
        check_eq("stray_nwrite", 64'(w_addr.size() - wb), 64'd0);
        fb = f_addr.size();
        do_start();
        run(12);
        if (f_addr.size() - fb >= 1)
            check_eq("restart_faddr", 64'(f_addr[fb]), 64'h0);
        check_eq("restart_nwrite", 64'(w_addr.size() - wb), 64'd1);
        if (w_addr.size() - wb >= 1)
            check_eq("restart_data", 64'(w_data[wb]), 64'd9);

        check_eq("no_overlap", 64'(overlap), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
